// File: rtl/dmem_store_buffer.sv
// Data-memory store buffer with load forwarding in front of a word RAM.
// Define STORE_COALESCE_EN to merge a store into the youngest entry when the word index matches.
module dmem_store_buffer #(
    parameter int DEPTH    = 64,
    parameter int SB_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          memwrite,
    input  logic                          memread,
    input  logic [31:0]                   dataaddr,
    input  logic [31:0]                   writedata,
    output logic [31:0]                   readdata,
    output logic                          stall,
    output logic [$clog2(SB_DEPTH+1)-1:0] sb_count,
    output logic                          sb_empty,
    output logic                          misalign
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = $clog2(SB_DEPTH + 1);

    logic [31:0]   ram     [DEPTH];
    logic [AW-1:0] sb_idx  [SB_DEPTH];
    logic [31:0]   sb_data [SB_DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] last;
    logic [AW-1:0] idx;
    logic          full;
    logic          drain;
    logic          merge;
    logic          enq;
    logic          hit;
    logic [31:0]   fwd_data;
    logic          unused_addr;

    assign idx         = dataaddr[AW+1:2];
    assign unused_addr = ^dataaddr[31:AW+2];
    assign last        = tail - PW'(1);

    assign sb_empty = (sb_count == '0);
    assign full     = (sb_count == CW'(SB_DEPTH));

    // Loads own the RAM port unless the buffer is full.
    assign drain = !sb_empty && (!memread || full);

`ifdef STORE_COALESCE_EN
    // The head entry leaving this cycle cannot absorb a new store.
    assign merge = memwrite && !sb_empty && (sb_idx[last] == idx)
                && !(drain && (sb_count == CW'(1)));
`else
    assign merge = 1'b0;
`endif

    assign stall = memwrite && full && !merge;
    assign enq   = memwrite && !full && !merge;

    // Scan oldest to youngest so the youngest match wins.
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            logic [PW-1:0] pos;
            pos = head + PW'(i);
            if ((CW'(i) < sb_count) && (sb_idx[pos] == idx)) begin
                hit      = 1'b1;
                fwd_data = sb_data[pos];
            end
        end
    end

    always_comb begin
        readdata = '0;
        if (memread) begin
            readdata = hit ? fwd_data : ram[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            sb_count <= '0;
            misalign <= 1'b0;
        end else begin
            if (enq) begin
                tail <= tail + PW'(1);
            end
            if (drain) begin
                head <= head + PW'(1);
            end
            sb_count <= sb_count + CW'(enq) - CW'(drain);
            if ((memwrite || memread) && (dataaddr[1:0] != 2'b00)) begin
                misalign <= 1'b1;
            end
        end
    end

    // Storage arrays carry no reset; reset only suppresses updates.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (enq) begin
                sb_idx[tail]  <= idx;
                sb_data[tail] <= writedata;
            end
            if (merge) begin
                sb_data[last] <= writedata;
            end
            if (drain) begin
                ram[sb_idx[head]] <= sb_data[head];
            end
        end
    end

endmodule
